mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter onto a single-port synchronous memory.
// Each granted transaction runs IDLE -> ACCESS -> DONE (three cycles).
// Build option MEM_ARBITER_RR_EN: when both masters request together, the
// master that was not granted last wins (round-robin). Without it, master 0
// always wins a tie (fixed priority).
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          m0_req,
    input  logic          m0_rnw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_din,
    output logic [DW-1:0] m0_dout,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_rnw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_din,
    output logic [DW-1:0] m1_dout,
    output logic          m1_ack,
    output logic          mem_cs_b,
    output logic          mem_rnw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dout,
    input  logic [DW-1:0] mem_din,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t state, next_state;
    logic   rnw_r;
    logic   any_req;
    logic   grant;

    assign any_req = m0_req | m1_req;

    // Pick the winning master; only meaningful while some request is high.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        grant = (m0_req && m1_req) ? ~owner : m1_req;
`else
        grant = ~m0_req;
`endif
    end

    // State register; reset always lands in IDLE, aborting any transaction.
    always_ff @(posedge clk) begin
        if (!reset_b) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state and memory strobe / ack decode.
    always_comb begin
        next_state = IDLE;
        mem_cs_b   = 1'b1;
        mem_rnw    = 1'b1;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        case (state)
            IDLE:    next_state = any_req ? ACCESS : IDLE;
            ACCESS: begin
                mem_cs_b   = 1'b0;
                mem_rnw    = rnw_r;
                next_state = DONE;
            end
            DONE: begin
                m0_ack     = ~owner;
                m1_ack     = owner;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the winner's request at grant; capture read data at end of ACCESS.
    // Address and write data stay put outside ACCESS so the bus does not toggle.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rnw_r    <= 1'b1;
            mem_addr <= '0;
            mem_dout <= '0;
            owner    <= 1'b1;
            m0_dout  <= '0;
            m1_dout  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner    <= grant;
                rnw_r    <= grant ? m1_rnw  : m0_rnw;
                mem_addr <= grant ? m1_addr : m0_addr;
                mem_dout <= grant ? m1_din  : m0_din;
            end
            if (state == ACCESS && rnw_r) begin
                if (owner) m1_dout <= mem_din;
                else       m0_dout <= mem_din;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes the
// expected memory access and ack into queues; a negedge monitor pops and
// compares whenever the DUT strobes the memory or acks a master.
// Honours MEM_ARBITER_RR_EN for the tie-break expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        m0_req, m0_rnw, m1_req, m1_rnw;
    logic [15:0] m0_addr, m0_din, m1_addr, m1_din;
    logic [15:0] m0_dout, m1_dout;
    logic        m0_ack, m1_ack;
    logic        mem_cs_b, mem_rnw;
    logic [15:0] mem_addr, mem_dout, mem_din;
    logic        owner;

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .reset_b(reset_b),
        .m0_req(m0_req), .m0_rnw(m0_rnw), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_dout(m0_dout), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_rnw(m1_rnw), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_dout(m1_dout), .m1_ack(m1_ack),
        .mem_cs_b(mem_cs_b), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic        rnw;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        int          m;
        logic [15:0] d0;
        logic [15:0] d1;
        int          cyc;
    } ack_exp_t;

    mem_exp_t    memq[$];
    ack_exp_t    ackq[$];
    logic [15:0] md[2];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Record an expected transaction whose memory strobe lands in cs_cyc.
    function automatic void exp_txn(int m, logic rnw, logic [15:0] addr,
                                    logic [15:0] wdata, logic [15:0] rdata, int cs_cyc);
        mem_exp_t me;
        ack_exp_t ae;
        me.m = m; me.rnw = rnw; me.addr = addr; me.data = wdata; me.cyc = cs_cyc;
        memq.push_back(me);
        if (rnw) md[m] = rdata;
        ae.m = m; ae.d0 = md[0]; ae.d1 = md[1]; ae.cyc = cs_cyc + 1;
        ackq.push_back(ae);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int m, logic req, logic rnw, logic [15:0] addr, logic [15:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_rnw = rnw; m0_addr = addr; m0_din = wdata;
        end else begin
            m1_req = req; m1_rnw = rnw; m1_addr = addr; m1_din = wdata;
        end
    endtask

    // Single transaction from IDLE; request fields are scrambled once latched.
    task automatic txn(int m, logic rnw, logic [15:0] addr, logic [15:0] wdata);
        exp_txn(m, rnw, addr, wdata, mem_din, cyc + 1);
        drive(m, 1'b1, rnw, addr, wdata);
        tick();
        drive(m, 1'b0, ~rnw, ~addr, ~wdata);
        tick();
        tick();
    endtask

    // Scoreboard monitor: compares every memory strobe and every ack.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (m0_ack || m1_ack) begin
                if (ackq.size() == 0) begin
                    chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
                end else begin
                    ack_exp_t a;
                    a = ackq.pop_front();
                    chk("ack_master", {30'd0, m1_ack, m0_ack}, (a.m != 0) ? 32'd2 : 32'd1);
                    chk("ack_m0_dout", {16'd0, m0_dout}, {16'd0, a.d0});
                    chk("ack_m1_dout", {16'd0, m1_dout}, {16'd0, a.d1});
                    chk("ack_cycle", cyc, a.cyc);
                end
            end
            if (!mem_cs_b) begin
                if (memq.size() == 0) begin
                    chk("unexpected_cs", {31'd0, mem_cs_b}, 32'd1);
                end else begin
                    mem_exp_t e;
                    e = memq.pop_front();
                    chk("mem_rnw", {31'd0, mem_rnw}, {31'd0, e.rnw});
                    chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    if (!e.rnw) chk("mem_wdata", {16'd0, mem_dout}, {16'd0, e.data});
                    chk("cs_cycle", cyc, e.cyc);
                    chk("owner", {31'd0, owner}, e.m);
                end
            end else begin
                chk("idle_rnw", {31'd0, mem_rnw}, 32'd1);
            end
        end
    end

    initial begin
        int q;
        reset_b = 1'b0;
        drive(0, 1'b0, 1'b1, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b1, 16'h0, 16'h0);
        mem_din = 16'h0;
        md[0] = 16'h0;
        md[1] = 16'h0;
        tick();
        tick();
        // reset values
        chk("rst_cs_b", {31'd0, mem_cs_b}, 32'd1);
        chk("rst_rnw", {31'd0, mem_rnw}, 32'd1);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_dout", {16'd0, mem_dout}, 32'd0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst_m0_dout", {16'd0, m0_dout}, 32'd0);
        chk("rst_m1_dout", {16'd0, m1_dout}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd1);
        mon_en = 1'b1;
        reset_b = 1'b1;
        tick();

        // basic read, write, dout hold
        mem_din = 16'hBEEF;
        txn(0, 1'b1, 16'h0123, 16'h0000);
        txn(1, 1'b0, 16'h0040, 16'h5A5A);
        mem_din = 16'h1234;
        txn(1, 1'b1, 16'h0200, 16'h0000);
        txn(0, 1'b0, 16'h0300, 16'hAAAA);
        mem_din = 16'h5555;
        txn(0, 1'b1, 16'h0301, 16'h0000);

        // both masters hold requests from reset release
        reset_b = 1'b0;
        tick();
        chk("rst2_owner", {31'd0, owner}, 32'd1);
        chk("rst2_m0_dout", {16'd0, m0_dout}, 32'd0);
        md[0] = 16'h0;
        md[1] = 16'h0;
        reset_b = 1'b1;
        mem_din = 16'h7777;
        drive(0, 1'b1, 1'b1, 16'h0A00, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0B00, 16'hB0B0);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_RR_EN
            if (k % 2 == 1) exp_txn(1, 1'b0, 16'h0B00, 16'hB0B0, mem_din, cyc + 1 + 3 * k);
            else            exp_txn(0, 1'b1, 16'h0A00, 16'h0000, mem_din, cyc + 1 + 3 * k);
`else
            exp_txn(0, 1'b1, 16'h0A00, 16'h0000, mem_din, cyc + 1 + 3 * k);
`endif
        end
        repeat (11) tick();
        drive(0, 1'b0, 1'b1, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b1, 16'h0, 16'h0);
        tick();

        // m1 request appears during m0 ACCESS, m0 keeps requesting
        q = cyc;
        mem_din = 16'hCAFE;
        exp_txn(0, 1'b1, 16'h0300, 16'h0000, mem_din, q + 1);
        drive(0, 1'b1, 1'b1, 16'h0300, 16'h0000);
        tick();
        drive(1, 1'b1, 1'b1, 16'h0400, 16'h0000);
        tick();
        mem_din = 16'h4444;
`ifdef MEM_ARBITER_RR_EN
        exp_txn(1, 1'b1, 16'h0400, 16'h0000, mem_din, q + 4);
`else
        exp_txn(0, 1'b1, 16'h0300, 16'h0000, mem_din, q + 4);
`endif
        repeat (3) tick();
        drive(0, 1'b0, 1'b1, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b1, 16'h0, 16'h0);
        tick();

        // reset during ACCESS aborts the read
        mem_din = 16'h9999;
        begin
            mem_exp_t me;
            me.m = 0; me.rnw = 1'b1; me.addr = 16'h0555; me.data = 16'h0; me.cyc = cyc + 1;
            memq.push_back(me);
        end
        drive(0, 1'b1, 1'b1, 16'h0555, 16'h0000);
        tick();
        reset_b = 1'b0;
        drive(0, 1'b0, 1'b1, 16'h0, 16'h0);
        tick();
        chk("abort_cs_b", {31'd0, mem_cs_b}, 32'd1);
        chk("abort_m0_dout", {16'd0, m0_dout}, 32'd0);
        chk("abort_owner", {31'd0, owner}, 32'd1);
        chk("abort_addr", {16'd0, mem_addr}, 32'd0);
        md[0] = 16'h0;
        md[1] = 16'h0;
        // first edge after reset release evaluates requests as IDLE
        reset_b = 1'b1;
        txn(1, 1'b0, 16'h0077, 16'h7777);

        // quiet bus
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("quiet_cs_b", {31'd0, mem_cs_b}, 32'd1);
            chk("quiet_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        end

        for (int i = 0; i < 20 && (memq.size() != 0 || ackq.size() != 0); i++) tick();
        chk("memq_drained", memq.size(), 32'd0);
        chk("ackq_drained", ackq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
